// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Arbitrates the level indications coming from a bank of interrupt samplers
//   and presents a single request at a time to the CPU exception logic. The
//   lowest-numbered pending source wins. Once the CPU acknowledges, a one-cycle
//   clear pulse goes back to the sampler of the accepted source, and no new
//   request is raised until the handler returns with eret.
//
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   ind        in   NUM_SRC  sampler indication lines (level, held until cleared)
//   ie         in   1        global interrupt enable from CPU
//   mask_we    in   1        write strobe for the mask register
//   mask_wdata in   NUM_SRC  new mask value (1 = source enabled)
//   int_ack    in   1        CPU accepted the request (1-cycle pulse)
//   eret       in   1        handler return (1-cycle pulse)
//   int_req    out  1        interrupt request to CPU
//   int_id     out  ID_W     id of the requested / in-service source
//   int_vec    out  32       VEC_BASE + int_id * VEC_STRIDE
//   smp_clr    out  NUM_SRC  one-hot 1-cycle clear pulse to the samplers
//   in_service out  1        a handler is running
//   mask       out  NUM_SRC  current mask register
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int unsigned        NUM_SRC    = 3,
  parameter int unsigned        ID_W       = 3,
  parameter logic [NUM_SRC-1:0] MASK_RESET = {NUM_SRC{1'b1}},
  parameter logic [31:0]        VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0]        VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] ind,
  input  logic               ie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [31:0]        int_vec,
  output logic [NUM_SRC-1:0] smp_clr,
  output logic               in_service,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    id_nxt;
  logic [NUM_SRC-1:0] clr_q;
  logic [NUM_SRC-1:0] clr_nxt;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending;
  logic [31:0]        id_ext;

  // Fixed priority: index 0 is the most urgent, so scan downwards and let the
  // lowest set bit overwrite any higher one.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  function automatic logic [NUM_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_SRC-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (id == ID_W'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // The registered mask is used, so a mask write only affects arbitration
  // from the cycle after the write edge.
  assign pending = ind & mask_q;

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    clr_nxt   = '0;
    case (state)
      IDLE: begin
        if (ie && (|pending)) begin
          id_nxt    = lowest_idx(pending);
          state_nxt = REQ;
        end
      end
      // The request is not withdrawn by ie, mask or a higher-priority
      // arrival; only the CPU acknowledge moves it on.
      REQ: begin
        if (int_ack) begin
          clr_nxt   = id_onehot(id_q);
          state_nxt = SVC;
        end
      end
      SVC: begin
        if (eret) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      id_q   <= '0;
      clr_q  <= '0;
      mask_q <= MASK_RESET;
    end else begin
      state <= state_nxt;
      id_q  <= id_nxt;
      clr_q <= clr_nxt;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign id_ext     = 32'(id_q);
  assign int_req    = (state == REQ);
  assign in_service = (state == SVC);
  assign int_id     = id_q;
  assign int_vec    = VEC_BASE + id_ext * VEC_STRIDE;
  assign smp_clr    = clr_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int NS = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] ind;
  logic          ie;
  logic          mask_we;
  logic [NS-1:0] mask_wdata;
  logic          int_ack;
  logic          eret;
  logic          int_req;
  logic [IW-1:0] int_id;
  logic [31:0]   int_vec;
  logic [NS-1:0] smp_clr;
  logic          in_service;
  logic [NS-1:0] mask;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk        (clk),
    .rst        (rst),
    .ind        (ind),
    .ie         (ie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_vec    (int_vec),
    .smp_clr    (smp_clr),
    .in_service (in_service),
    .mask       (mask)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Applies one cycle of inputs ahead of a rising edge, then samples after it.
  task automatic drive(input logic r, input logic [NS-1:0] i, input logic e,
                       input logic we, input logic [NS-1:0] wd,
                       input logic a, input logic er);
    @(negedge clk);
    rst = r; ind = i; ie = e; mask_we = we; mask_wdata = wd;
    int_ack = a; eret = er;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [NS-1:0] ind;
    logic          ie;
    logic          we;
    logic [NS-1:0] wd;
    logic          ack;
    logic          eret;
    logic          req;
    logic [IW-1:0] id;
    logic [NS-1:0] clr;
    logic          svc;
    logic [NS-1:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [NS-1:0] i, logic e, logic we,
                              logic [NS-1:0] wd, logic a, logic er,
                              logic q, logic [IW-1:0] d, logic [NS-1:0] c,
                              logic s, logic [NS-1:0] m);
    vec_t v;
    v.rst = r; v.ind = i; v.ie = e; v.we = we; v.wd = wd; v.ack = a; v.eret = er;
    v.req = q; v.id = d; v.clr = c; v.svc = s; v.mask = m;
    return v;
  endfunction

  // Reference model: a request is outstanding, a handler is running, or
  // neither. Arbitration picks the smallest enabled index.
  bit          m_waiting;
  bit          m_busy;
  int          m_id;
  logic [NS-1:0] m_mask;
  logic [NS-1:0] m_clr;

  task automatic model_step(input logic r, input logic [NS-1:0] i, input logic e,
                            input logic we, input logic [NS-1:0] wd,
                            input logic a, input logic er);
    int winner;
    logic [NS-1:0] p;
    if (r) begin
      m_waiting = 0; m_busy = 0; m_id = 0; m_mask = '1; m_clr = '0;
      return;
    end
    m_clr = '0;
    p = i & m_mask;
    if (!m_waiting && !m_busy) begin
      winner = -1;
      for (int k = 0; k < NS; k++) if (p[k] && winner < 0) winner = k;
      if (e && winner >= 0) begin
        m_id = winner;
        m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (a) begin
        m_clr = NS'(1 << m_id);
        m_waiting = 0;
        m_busy = 1;
      end
    end else begin
      if (er) m_busy = 0;
    end
    if (we) m_mask = wd;
  endtask

  initial begin
    logic [NS-1:0] sind;
    logic r, e, we, a, er;
    logic [NS-1:0] wd;

    rst = 1; ind = '0; ie = 0; mask_we = 0; mask_wdata = '0; int_ack = 0; eret = 0;

    //                rst ind    ie we wd     ack eret  req id clr    svc mask
    tbl.push_back(mk(1, 3'b000, 0, 0, 3'b000, 0, 0,   0, 0, 3'b000, 0, 3'b111));
    // single source, ack and return
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 0, 0,   1, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 1, 0,   0, 1, 3'b010, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 0,   0, 1, 3'b000, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 1,   0, 1, 3'b000, 0, 3'b111));
    // priority and no preemption while requesting
    tbl.push_back(mk(0, 3'b110, 1, 0, 3'b000, 0, 0,   1, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b000, 0, 0,   1, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b000, 1, 0,   0, 1, 3'b010, 1, 3'b111));
    tbl.push_back(mk(0, 3'b101, 1, 0, 3'b000, 0, 1,   0, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b101, 1, 0, 3'b000, 0, 0,   1, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b101, 1, 0, 3'b000, 1, 0,   0, 0, 3'b001, 1, 3'b111));
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 0, 1,   0, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 0, 0,   1, 2, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 1, 0,   0, 2, 3'b100, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 1,   0, 2, 3'b000, 0, 3'b111));
    // mask blocks, mask write takes effect one cycle later
    tbl.push_back(mk(0, 3'b000, 1, 1, 3'b101, 0, 0,   0, 2, 3'b000, 0, 3'b101));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 0, 0,   0, 2, 3'b000, 0, 3'b101));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 0, 0,   0, 2, 3'b000, 0, 3'b101));
    tbl.push_back(mk(0, 3'b010, 1, 1, 3'b111, 0, 0,   0, 2, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 0, 0,   1, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 1, 0,   0, 1, 3'b010, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 1,   0, 1, 3'b000, 0, 3'b111));
    // global enable gating; ie drop and mask clear do not withdraw
    tbl.push_back(mk(0, 3'b001, 0, 0, 3'b000, 0, 0,   0, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 0, 0, 3'b000, 0, 0,   0, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 0, 0,   1, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 0, 0, 3'b000, 0, 0,   1, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 0, 1, 3'b000, 0, 0,   1, 0, 3'b000, 0, 3'b000));
    tbl.push_back(mk(0, 3'b001, 0, 0, 3'b000, 1, 0,   0, 0, 3'b001, 1, 3'b000));
    tbl.push_back(mk(0, 3'b000, 0, 1, 3'b111, 0, 1,   0, 0, 3'b000, 0, 3'b111));
    // arrival during service is served after eret; stray eret/ack ignored
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 0, 0,   1, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b010, 1, 0, 3'b000, 1, 0,   0, 1, 3'b010, 1, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 0, 0,   0, 1, 3'b000, 1, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 1, 0,   0, 1, 3'b000, 1, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 0, 1,   0, 1, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 0, 0,   1, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b000, 1, 0,   0, 0, 3'b001, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 1,   0, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 1,   0, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 1, 0,   0, 0, 3'b000, 0, 3'b111));
    // reset during REQ (with ack) and during SVC (with eret, altered mask)
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 0, 0,   1, 2, 3'b000, 0, 3'b111));
    tbl.push_back(mk(1, 3'b100, 1, 0, 3'b000, 1, 0,   0, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 0, 0,   1, 2, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b100, 1, 0, 3'b000, 1, 0,   0, 2, 3'b100, 1, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 1, 3'b010, 0, 0,   0, 2, 3'b000, 1, 3'b010));
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 1,   0, 0, 3'b000, 0, 3'b111));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 0,   0, 0, 3'b000, 0, 3'b111));

    for (int t = 0; t < tbl.size(); t++) begin
      drive(tbl[t].rst, tbl[t].ind, tbl[t].ie, tbl[t].we, tbl[t].wd,
            tbl[t].ack, tbl[t].eret);
      check("vec_int_req",    t, 32'(int_req),    32'(tbl[t].req));
      check("vec_int_id",     t, 32'(int_id),     32'(tbl[t].id));
      check("vec_int_vec",    t, int_vec,         32'h100 + 32'(tbl[t].id) * 32'h10);
      check("vec_smp_clr",    t, 32'(smp_clr),    32'(tbl[t].clr));
      check("vec_in_service", t, 32'(in_service), 32'(tbl[t].svc));
      check("vec_mask",       t, 32'(mask),       32'(tbl[t].mask));
    end

    // Randomized traffic with a sampler model feeding ind.
    model_step(1, '0, 0, 0, '0, 0, 0);
    drive(1, '0, 0, 0, '0, 0, 0);
    sind = '0;
    for (int c = 0; c < 3000; c++) begin
      sind = sind & ~m_clr;
      for (int k = 0; k < NS; k++) if ($urandom_range(0, 7) == 0) sind[k] = 1'b1;
      r  = ($urandom_range(0, 149) == 0);
      e  = ($urandom_range(0, 4) != 0);
      we = ($urandom_range(0, 19) == 0);
      wd = NS'($urandom);
      a  = ($urandom_range(0, 2) == 0);
      er = ($urandom_range(0, 3) == 0);
      model_step(r, sind, e, we, wd, a, er);
      drive(r, sind, e, we, wd, a, er);
      check("rnd_int_req",    c, 32'(int_req),    32'(m_waiting));
      check("rnd_in_service", c, 32'(in_service), 32'(m_busy));
      check("rnd_int_id",     c, 32'(int_id),     32'(m_id));
      check("rnd_int_vec",    c, int_vec,         32'h100 + 32'(m_id) * 32'h10);
      check("rnd_smp_clr",    c, 32'(smp_clr),    32'(m_clr));
      check("rnd_mask",       c, 32'(mask),       32'(m_mask));
      check("rnd_clr_onehot", c, 32'($countones(smp_clr) <= 1), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
